// File: rtl/data_ram_responder.sv
// Data-side RAM responder: word-addressed array behind a stalling SRAM protocol with wait states.
// Optional macro DATA_RAM_POSTED_WRITE_EN commits writes at the accept edge, bypassing the wait states.
module data_ram_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_wdata_i,
  output logic [31:0] ram_data_o,
  output logic        ram_stall_o,
  output logic        data_ok_o,
  output logic        addr_err_o
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                err_q;
  logic [31:0]         mem [0:DEPTH-1];

  logic                idle_c;
  logic                in_region_c;
  logic                accept_c;
  logic                short_c;
  logic                fin_c;
  logic                req_we_c;
  logic [3:0]          req_sel_c;
  logic [31:0]         req_wdata_c;
  logic [ADDR_W-1:0]   req_idx_c;
  logic                req_err_c;
  logic                unused_c;

  assign unused_c    = ^ram_addr_i[1:0];
  assign idle_c      = (state == S_IDLE);
  assign in_region_c = (ram_addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign accept_c    = idle_c & ram_ce_i;

`ifdef DATA_RAM_POSTED_WRITE_EN
  assign short_c = accept_c & ram_we_i;
`else
  assign short_c = 1'b0;
`endif

  // Request in flight: live inputs on the zero-wait path, latched copy once waiting.
  assign req_we_c    = idle_c ? ram_we_i    : we_q;
  assign req_sel_c   = idle_c ? ram_sel_i   : sel_q;
  assign req_wdata_c = idle_c ? ram_wdata_i : wdata_q;
  assign req_idx_c   = idle_c ? ram_addr_i[ADDR_W+1:2] : idx_q;
  assign req_err_c   = idle_c ? ~in_region_c : err_q;

  // Edge that enters RESP: commit/read happens here so results are valid with data_ok_o.
  assign fin_c = (accept_c & (NO_WAIT | short_c)) | ((state == S_WAIT) & (cnt_q == 4'd0));

  assign ram_stall_o = accept_c | (state == S_WAIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      ram_data_o <= 32'd0;
      data_ok_o  <= 1'b0;
      addr_err_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ram_ce_i) begin
            we_q    <= ram_we_i;
            sel_q   <= ram_sel_i;
            wdata_q <= ram_wdata_i;
            idx_q   <= ram_addr_i[ADDR_W+1:2];
            err_q   <= ~in_region_c;
            if (fin_c) begin
              state <= S_RESP;
            end else begin
              cnt_q <= WAIT_LOAD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state <= S_RESP;
          else               cnt_q <= cnt_q - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      data_ok_o  <= fin_c;
      addr_err_o <= fin_c & req_err_c;
      if (fin_c && !req_we_c) ram_data_o <= req_err_c ? 32'd0 : mem[req_idx_c];
    end
  end

  // Array is not reset; only enabled lanes of an in-region write are updated.
  always_ff @(posedge clk_i) begin
    if (rst_i && fin_c && req_we_c && !req_err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (req_sel_c[k]) mem[req_idx_c][8*k +: 8] <= req_wdata_c[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_data_ram_responder;

`ifdef DATA_RAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  localparam int WR_LAT2 = POSTED ? 1 : 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce2 = 1'b0, ce0 = 1'b0;
  logic        we_r = 1'b0;
  logic [3:0]  sel_r = 4'd0;
  logic [31:0] addr_r = 32'd0, wdata_r = 32'd0;
  logic [31:0] data2, data0;
  logic        stall2, stall0, ok2, ok0, err2, err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_W(12), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .ram_ce_i(ce2), .ram_we_i(we_r), .ram_sel_i(sel_r),
    .ram_addr_i(addr_r), .ram_wdata_i(wdata_r), .ram_data_o(data2),
    .ram_stall_o(stall2), .data_ok_o(ok2), .addr_err_o(err2)
  );

  data_ram_responder #(.ADDR_W(12), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .ram_ce_i(ce0), .ram_we_i(we_r), .ram_sel_i(sel_r),
    .ram_addr_i(addr_r), .ram_wdata_i(wdata_r), .ram_data_o(data0),
    .ram_stall_o(stall0), .data_ok_o(ok0), .addr_err_o(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one request just after a rising edge, hold it until data_ok_o, measure latency and stalls.
  task automatic acc(input bit which, input logic we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output int stalls, output logic [31:0] rdata, output logic err);
    bit done;
    done = 1'b0;
    we_r = we; sel_r = sel; addr_r = addr; wdata_r = wdata;
    if (which) ce0 = 1'b1; else ce2 = 1'b1;
    lat = 0; stalls = 0; rdata = 32'd0; err = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (which ? stall0 : stall2) stalls++;
      if (which ? ok0 : ok2) begin
        done  = 1'b1;
        rdata = which ? data0 : data2;
        err   = which ? err0 : err2;
      end
      @(posedge clk); #1;
      if (!done) lat++;
    end
    ce0 = 1'b0; ce2 = 1'b0;
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input string tag, input bit which, input logic we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
    int lat, stalls;
    logic [31:0] rdata;
    logic err;
    acc(which, we, sel, addr, wdata, lat, stalls, rdata, err);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".stall"}, 32'(stalls), 32'(exp_lat));
    check({tag, ".data"}, rdata, exp_data);
    check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst.data", data2, 32'd0);
    check("rst.ok", {31'd0, ok2}, 32'd0);
    check("rst.err", {31'd0, err2}, 32'd0);
    check("rst.stall", {31'd0, stall2}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Full word, lane merge, empty sel
    txn("w_full", 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, WR_LAT2, 32'd0, 1'b0);
    txn("r_full", 1'b0, 1'b0, 4'hF, 32'h10, 32'd0, 3, 32'hDEADBEEF, 1'b0);
    txn("w_lane", 1'b0, 1'b1, 4'b0010, 32'h10, 32'h0000_5500, WR_LAT2, 32'hDEADBEEF, 1'b0);
    txn("r_lane", 1'b0, 1'b0, 4'hF, 32'h10, 32'd0, 3, 32'hDEAD55EF, 1'b0);
    txn("w_sel0", 1'b0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, WR_LAT2, 32'hDEAD55EF, 1'b0);
    txn("r_sel0", 1'b0, 1'b0, 4'b0001, 32'h10, 32'd0, 3, 32'hDEAD55EF, 1'b0);

    // Out of region: no alias into word 0, read returns zero
    txn("w_zero", 1'b0, 1'b1, 4'hF, 32'h0, 32'hA5A5_0001, WR_LAT2, 32'hDEAD55EF, 1'b0);
    txn("w_oor", 1'b0, 1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678, WR_LAT2, 32'hDEAD55EF, 1'b1);
    txn("r_zero", 1'b0, 1'b0, 4'hF, 32'h0, 32'd0, 3, 32'hA5A5_0001, 1'b0);
    txn("r_oor", 1'b0, 1'b0, 4'hF, 32'h0001_0000, 32'd0, 3, 32'd0, 1'b1);

    // Reset in the middle of a write
    txn("w_old", 1'b0, 1'b1, 4'hF, 32'h40, 32'h1111_2222, WR_LAT2, 32'd0, 1'b0);
    we_r = 1'b1; sel_r = 4'hF; addr_r = 32'h40; wdata_r = 32'hCAFEF00D; ce2 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ce2 = 1'b0;
    #1;
    check("mid.ok", {31'd0, ok2}, 32'd0);
    check("mid.data", data2, 32'd0);
    check("mid.err", {31'd0, err2}, 32'd0);
    check("mid.stall", {31'd0, stall2}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid.noack", {31'd0, ok2}, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    txn("r_mid", 1'b0, 1'b0, 4'hF, 32'h40, 32'd0, 3, POSTED ? 32'hCAFEF00D : 32'h1111_2222, 1'b0);

    // Zero-wait instance, back to back with ce held through RESP
    txn("z_w20", 1'b1, 1'b1, 4'hF, 32'h20, 32'h2020_2020, 1, 32'd0, 1'b0);
    txn("z_r20", 1'b1, 1'b0, 4'hF, 32'h20, 32'd0, 1, 32'h2020_2020, 1'b0);
    txn("z_w24", 1'b1, 1'b1, 4'hF, 32'h24, 32'h2424_2424, 1, 32'h2020_2020, 1'b0);
    txn("z_r20b", 1'b1, 1'b0, 4'hF, 32'h20, 32'd0, 1, 32'h2020_2020, 1'b0);
    txn("z_r24", 1'b1, 1'b0, 4'hF, 32'h24, 32'd0, 1, 32'h2424_2424, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
